servo_pwm_sequencer: RTL and testbench
======================================

SERVO_PWM_SEQUENCER -- requirements
Module: servo_pwm_sequencer

Interface
REQ-001 Parameter TICK_DIV, 100, clk cycles per 1 us tick (100 MHz Basys3 clock).
REQ-002 Parameter FRAME_US, 20000, servo frame period in us (50 Hz).
REQ-003 Parameter MIN_US, 1250, lowest permitted pulse width in us.
REQ-004 Parameter MAX_US, 1750, highest permitted pulse width in us.
REQ-005 Parameter CENTER_US, 1500, neutral pulse width in us.
REQ-006 Parameter STEP_US, 10, maximum pulse-width change per frame in us.
REQ-007 clk  input  1  system clock.
REQ-008 rst  input  1  reset: synchronous, active-high.
REQ-009 target_us  input  11  requested pulse width in us (unsigned).
REQ-010 target_valid  input  1  one-cycle strobe qualifying target_us.
REQ-011 enable  input  1  level; 0 holds the output low and parks the sequencer.
REQ-012 pwm_out  output  1  servo control pulse.
REQ-013 cur_us  output  11  pulse width applied in the current frame.
REQ-014 frame_start  output  1  one-cycle pulse on the first clk of each frame.
REQ-015 at_target  output  1  high when cur_us equals the latched, clamped target.

Function
REQ-016 The block SHALL generate a 1 us tick using a prescaler that counts 0..TICK_DIV-1 and wraps; the tick is asserted on the wrap cycle.
REQ-017 The block SHALL count ticks within a frame from 0 to FRAME_US-1 and then wrap to 0.
REQ-018 The FSM SHALL have the states IDLE, HIGH and LOW.
REQ-019 IDLE: pwm_out=0, prescaler and frame counter held at 0; go to HIGH on the first clk with enable=1.
REQ-020 HIGH: pwm_out=1 until the frame tick count reaches cur_us; then go to LOW.
REQ-021 LOW: pwm_out=0 until the frame counter wraps; then go to HIGH (enable=1) or IDLE (enable=0).
REQ-022 frame_start SHALL pulse on IDLE->HIGH and LOW->HIGH transitions only.
REQ-023 On target_valid, target_us SHALL be clamped to [MIN_US, MAX_US] and latched into the target register the next cycle.
REQ-024 A target_valid strobe mid-frame SHALL NOT alter cur_us before the next frame_start.
REQ-025 When several strobes fall within one frame, the last one wins.
REQ-026 On each frame_start, cur_us SHALL move toward the target by min(|target-cur_us|, STEP_US), so pulse width within a frame is constant.
REQ-027 The slew arithmetic SHALL use 12-bit signed intermediates; cur_us SHALL never leave [MIN_US, MAX_US].
REQ-028 When target_valid and frame_start coincide, the slew SHALL use the previously latched target and the new target takes effect next frame.
REQ-029 Deasserting enable mid-pulse SHALL complete the current frame normally; enable is sampled only at frame wrap.
REQ-030 at_target SHALL be a registered compare, updated one cycle after cur_us or the target changes.
REQ-031 All outputs SHALL be registered; pwm_out rises in the same cycle frame_start is high.

Reset
REQ-032 On rst, the FSM SHALL enter IDLE with pwm_out=0, frame_start=0, cur_us=CENTER_US, target=CENTER_US, at_target=1, and the prescaler and frame counter at 0.
REQ-033 rst asserted mid-pulse SHALL drive pwm_out low on the next clk, with no partial-frame resumption.

Structure
REQ-034 Package servo_pkg SHALL hold the timing and limit constants (TICK_DIV, FRAME_US, MIN_US, MAX_US, CENTER_US, STEP_US), the 11-bit us_t typedef and the FSM state enum.
REQ-035 The prescaler SHALL be a separate sub-module, us_tick_gen.
REQ-036 The clamp, slew, FSM and counters SHALL reside in servo_pwm_sequencer.

Verification
REQ-037 Reset then enable=1 with no target: every frame pwm_out high 150000 clk and low 1850000 clk; cur_us=1500.
REQ-038 target_us=2000 strobe: target clamps to 1750; cur_us reaches 1750 after 25 frames (1510, 1520, ...); then at_target=1.
REQ-039 target_us=1000 from 1500: cur_us follows 1490 ... 1250 over 25 frames; clamped at 1250.
REQ-040 Strobes 1600 then 1400 in the same frame: next frame cur_us=1490; 1600 is never applied.
REQ-041 target_valid in the frame_start cycle with target 1700 (previous 1500, cur 1500): that frame cur_us=1500; next frame 1510.
REQ-042 rst mid-HIGH at cur_us=1700: pwm_out=0 next clk; cur_us=1500; IDLE until enable.

Source files
------------

// File: rtl/servo_pkg.sv
// servo_pkg: shared timing/limit constants, types and clamp helper for the servo PWM sequencer
package servo_pkg;
    localparam int TICK_DIV  = 100;
    localparam int FRAME_US  = 20000;
    localparam int MIN_US    = 1250;
    localparam int MAX_US    = 1750;
    localparam int CENTER_US = 1500;
    localparam int STEP_US   = 10;
    typedef logic [10:0] us_t;
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
    function automatic us_t clamp_us(us_t v, us_t lo, us_t hi);
        return v < lo ? lo : v > hi ? hi : v;
    endfunction
endpackage

// File: rtl/servo_pwm_sequencer_if.sv
// servo_pwm_sequencer_if: target/enable inputs and PWM status outputs of the sequencer
interface servo_pwm_sequencer_if;
    import servo_pkg::*;
    us_t  target_us;
    logic target_valid;
    logic enable;
    logic pwm_out;
    us_t  cur_us;
    logic frame_start;
    logic at_target;
    modport master (output target_us, target_valid, enable, input pwm_out, cur_us, frame_start, at_target);
    modport slave  (input target_us, target_valid, enable, output pwm_out, cur_us, frame_start, at_target);
endinterface

// File: rtl/servo_pwm_sequencer_tick.sv
// us_tick_gen: prescaler counting 0..DIV-1, tick on the wrap cycle, held at 0 while clr
module us_tick_gen #(
    parameter int DIV = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int W = DIV > 1 ? $clog2(DIV) : 1;
    logic [W-1:0] cnt;
    assign tick = !clr && int'(cnt) == DIV - 1;
    always_ff @(posedge clk)
        cnt <= (rst || clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/servo_pwm_sequencer.sv
// servo_pwm_sequencer: framed servo PWM with clamped target and per-frame slew limiting
module servo_pwm_sequencer #(
    parameter int TICK_DIV  = servo_pkg::TICK_DIV,
    parameter int FRAME_US  = servo_pkg::FRAME_US,
    parameter int MIN_US    = servo_pkg::MIN_US,
    parameter int MAX_US    = servo_pkg::MAX_US,
    parameter int CENTER_US = servo_pkg::CENTER_US,
    parameter int STEP_US   = servo_pkg::STEP_US
) (
    input logic clk,
    input logic rst,
    servo_pwm_sequencer_if.slave bus
);
    import servo_pkg::*;
    localparam int FW = FRAME_US > 1 ? $clog2(FRAME_US) : 1;
    localparam logic signed [11:0] S = 12'(STEP_US);
    state_t state, nxt;
    logic tick, clr, fwrap, hit, start;
    logic [FW-1:0] fcnt;
    us_t tgt, cur_n;
    logic signed [11:0] diff, step;
    assign clr = state == IDLE;
    us_tick_gen #(.DIV(TICK_DIV)) u_tick (.clk, .rst, .clr, .tick);
    always_comb begin
        fwrap = tick && int'(fcnt) == FRAME_US - 1;
        // end the pulse on the tick that carries the frame count up to cur_us
        hit = tick && int'(fcnt) + 1 == int'(bus.cur_us);
        nxt = state == IDLE ? (bus.enable ? HIGH : IDLE) :
              state == HIGH ? (hit ? LOW : HIGH) :
              fwrap ? (bus.enable ? HIGH : IDLE) : LOW;
        start = nxt == HIGH && state != HIGH;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, bus.cur_us});
        step = diff > S ? S : diff < -S ? -S : diff;
        cur_n = us_t'($signed({1'b0, bus.cur_us}) + step);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            fcnt            <= '0;
            tgt             <= us_t'(CENTER_US);
            bus.cur_us      <= us_t'(CENTER_US);
            bus.pwm_out     <= 1'b0;
            bus.frame_start <= 1'b0;
            bus.at_target   <= 1'b1;
        end else begin
            state           <= nxt;
            fcnt            <= (clr || fwrap) ? '0 : tick ? fcnt + 1'b1 : fcnt;
            bus.pwm_out     <= nxt == HIGH;
            bus.frame_start <= start;
            bus.at_target   <= bus.cur_us == tgt;
            if (start) bus.cur_us <= cur_n;
            if (bus.target_valid) tgt <= clamp_us(bus.target_us, us_t'(MIN_US), us_t'(MAX_US));
        end
    end
endmodule

// File: tb/tb_servo_pwm_sequencer.sv
// tb_servo_pwm_sequencer: frame-timing reference model plus directed slew/clamp/reset scenarios
module tb_servo_pwm_sequencer;
    localparam int TD = 2, FR = 200, MN = 60, MX = 140, CEN = 100, ST = 10;
    localparam int FRAME_CLK = FR * TD;
    logic clk = 0, rst = 1;
    int pass = 0, total = 0;
    bit mon = 0;
    servo_pwm_sequencer_if bus ();
    servo_pwm_sequencer #(.TICK_DIV(TD), .FRAME_US(FR), .MIN_US(MN), .MAX_US(MX),
                          .CENTER_US(CEN), .STEP_US(ST)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        else pass++;
    endtask

    // model: a frame is a run of FRAME_CLK cycles; pulse is high for the first cur*TD of them
    bit m_run = 0, e_pwm = 0, e_fs = 0, e_at = 1;
    int m_pos = 0, m_cur = CEN, m_tgt = CEN;
    always @(posedge clk) begin
        bit bf;
        int d, at_n;
        if (rst) begin
            m_run = 0; m_pos = 0; m_cur = CEN; m_tgt = CEN;
            e_pwm = 0; e_fs = 0; e_at = 1;
        end else begin
            at_n = (m_cur == m_tgt);
            bf = 0;
            if (!m_run) begin
                if (bus.enable) begin m_run = 1; m_pos = 0; bf = 1; end
            end else if (m_pos == FRAME_CLK - 1) begin
                if (bus.enable) begin m_pos = 0; bf = 1; end
                else m_run = 0;
            end else m_pos++;
            if (bf) begin
                d = m_tgt - m_cur;
                d = d > ST ? ST : d < -ST ? -ST : d;
                m_cur = m_cur + d;
            end
            if (bus.target_valid)
                m_tgt = bus.target_us < MN ? MN : bus.target_us > MX ? MX : int'(bus.target_us);
            e_fs = bf;
            e_pwm = m_run && m_pos < m_cur * TD;
            e_at = at_n[0];
        end
    end

    always @(negedge clk) if (mon) begin
        chk("pwm_out", bus.pwm_out, e_pwm);
        chk("frame_start", bus.frame_start, e_fs);
        chk("cur_us", bus.cur_us, m_cur);
        chk("at_target", bus.at_target, e_at);
    end

    task automatic next_fs();
        int n = 0;
        do begin @(negedge clk); n++; end while (!bus.frame_start && n < 2 * FRAME_CLK);
        chk("frame_start_wait", bus.frame_start, 1);
    endtask

    task automatic strobe(input int v);
        bus.target_us = 11'(v);
        bus.target_valid = 1;
        @(negedge clk);
        bus.target_valid = 0;
    endtask

    initial begin
        int hi, n, fs;
        bus.target_us = 0; bus.target_valid = 0; bus.enable = 0;
        repeat (3) @(negedge clk);
        mon = 1;
        rst = 0;
        chk("rst_cur", bus.cur_us, 100);
        chk("rst_at", bus.at_target, 1);
        chk("rst_pwm", bus.pwm_out, 0);
        repeat (5) @(negedge clk);
        chk("idle_pwm", bus.pwm_out, 0);
        bus.enable = 1;
        next_fs();
        chk("first_cur", bus.cur_us, 100);
        hi = 0; n = 0;
        do begin hi += bus.pwm_out; n++; @(negedge clk); end while (!bus.frame_start && n < 1000);
        chk("high_clk", hi, 200);
        chk("frame_clk", n, 400);
        repeat (5) @(negedge clk);
        strobe(200);
        @(negedge clk);
        chk("at_after_strobe", bus.at_target, 0);
        for (int v = 110; v <= 140; v += 10) begin next_fs(); chk("slew_up", bus.cur_us, v); end
        @(negedge clk);
        chk("at_max", bus.at_target, 1);
        repeat (5) @(negedge clk);
        strobe(20);
        for (int v = 130; v >= 60; v -= 10) begin next_fs(); chk("slew_down", bus.cur_us, v); end
        repeat (5) @(negedge clk);
        strobe(100);
        for (int v = 70; v <= 100; v += 10) begin next_fs(); chk("slew_back", bus.cur_us, v); end
        repeat (10) @(negedge clk);
        strobe(120);
        repeat (10) @(negedge clk);
        strobe(80);
        next_fs();
        chk("last_wins", bus.cur_us, 90);
        next_fs();
        chk("last_wins2", bus.cur_us, 80);
        strobe(130);
        chk("coincide_now", bus.cur_us, 80);
        next_fs();
        chk("coincide_next", bus.cur_us, 90);
        repeat (50) @(negedge clk);
        bus.enable = 0;
        chk("en_drop_high", bus.pwm_out, 1);
        fs = 0;
        repeat (800) begin @(negedge clk); fs += bus.frame_start; end
        chk("parked_fs", fs, 0);
        chk("parked_pwm", bus.pwm_out, 0);
        bus.enable = 1;
        for (int v = 100; v <= 130; v += 10) begin next_fs(); chk("resume", bus.cur_us, v); end
        repeat (40) @(negedge clk);
        chk("mid_high", bus.pwm_out, 1);
        rst = 1;
        @(negedge clk);
        chk("rst_mid_pwm", bus.pwm_out, 0);
        chk("rst_mid_cur", bus.cur_us, 100);
        rst = 0;
        bus.enable = 0;
        fs = 0;
        repeat (20) begin @(negedge clk); fs += bus.frame_start; end
        chk("post_rst_idle", fs + bus.pwm_out, 0);
        bus.enable = 1;
        next_fs();
        chk("post_rst_cur", bus.cur_us, 100);
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
